// File: rtl/raster_timing_gen.sv
// Raster timing master: scans hcnt/vcnt, strobes fsync, composites layer A over B over BG_COLOR.
// Video out is 1 cycle after hpos/vpos; no backpressure. Optional RASTER_TEST_PATTERN_EN adds test_en colour bars.
module raster_timing_gen #(
    parameter int          HRES     = 1280,
    parameter int          VRES     = 720,
    parameter int          H_FP     = 110,
    parameter int          H_SYNC   = 40,
    parameter int          H_BP     = 220,
    parameter int          V_FP     = 5,
    parameter int          V_SYNC   = 5,
    parameter int          V_BP     = 20,
    parameter bit          SYNC_POL = 1'b1,
    parameter logic [23:0] BG_COLOR = 24'h000000
) (
    input  logic                pixel_clk,
    input  logic                rst,
`ifdef RASTER_TEST_PATTERN_EN
    input  logic                test_en,
`endif
    output logic signed [11:0]  hpos,
    output logic signed [11:0]  vpos,
    output logic                fsync,
    input  logic [2:0][7:0]     obj_a_pixel,
    input  logic                obj_a_active,
    input  logic [2:0][7:0]     obj_b_pixel,
    input  logic                obj_b_active,
    output logic [15:0]         frame_cnt,
    output logic                vid_hsync,
    output logic                vid_vsync,
    output logic                vid_de,
    output logic [2:0][7:0]     vid_pixel
);

    localparam int H_TOTAL = HRES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = VRES + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT    = 12'(HRES);
    localparam logic [11:0] V_ACT    = 12'(VRES);
    localparam logic [11:0] HS_START = 12'(HRES + H_FP);
    localparam logic [11:0] HS_END   = 12'(HRES + H_FP + H_SYNC - 1);
    localparam logic [11:0] VS_START = 12'(VRES + V_FP);
    localparam logic [11:0] VS_END   = 12'(VRES + V_FP + V_SYNC - 1);

    logic [11:0] hcnt_q, hcnt_d;
    logic [11:0] vcnt_q, vcnt_d;
    logic        fsync_q, fsync_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        vid_hsync_q, vid_hsync_d;
    logic        vid_vsync_q, vid_vsync_d;
    logic        vid_de_q, vid_de_d;
    logic [23:0] vid_pixel_q, vid_pixel_d;

    logic        de_raw;
    logic        hs_raw;
    logic        vs_raw;
    logic [23:0] comp_rgb;

    // Scan counters; fsync is derived from the next count so it lines up with hpos=0/vpos=VRES.
    always_comb begin
        hcnt_d = hcnt_q + 12'd1;
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST) begin
            hcnt_d = 12'd0;
            vcnt_d = (vcnt_q == V_LAST) ? 12'd0 : vcnt_q + 12'd1;
        end
        fsync_d     = (hcnt_d == 12'd0) && (vcnt_d == V_ACT);
        frame_cnt_d = frame_cnt_q + {15'd0, fsync_d};
    end

    always_comb begin
        de_raw = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
        hs_raw = (hcnt_q >= HS_START) && (hcnt_q <= HS_END);
        vs_raw = (vcnt_q >= VS_START) && (vcnt_q <= VS_END);
    end

`ifdef RASTER_TEST_PATTERN_EN
    logic [2:0]  bar_idx;
    logic [23:0] bar_rgb;

    // Bar index is floor(hcnt*8/HRES); a plain hcnt>>7 would give 128-pixel bars at 1280.
    always_comb begin
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if ({hcnt_q, 3'b000} >= 15'(k * HRES)) begin
                bar_idx = 3'(k);
            end
        end
        bar_rgb = {{8{bar_idx[2]}}, {8{bar_idx[1]}}, {8{bar_idx[0]}}};
    end
`endif

    always_comb begin
        comp_rgb = BG_COLOR;
        if (obj_a_active) begin
            comp_rgb = obj_a_pixel;
        end else if (obj_b_active) begin
            comp_rgb = obj_b_pixel;
        end
`ifdef RASTER_TEST_PATTERN_EN
        if (test_en) begin
            comp_rgb = bar_rgb;
        end
`endif
    end

    always_comb begin
        vid_de_d    = de_raw;
        vid_pixel_d = de_raw ? comp_rgb : 24'd0;
        vid_hsync_d = hs_raw ? SYNC_POL : ~SYNC_POL;
        vid_vsync_d = vs_raw ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            hcnt_q      <= 12'd0;
            vcnt_q      <= 12'd0;
            fsync_q     <= 1'b0;
            frame_cnt_q <= 16'd0;
            vid_de_q    <= 1'b0;
            vid_pixel_q <= 24'd0;
            vid_hsync_q <= ~SYNC_POL;
            vid_vsync_q <= ~SYNC_POL;
        end else begin
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            fsync_q     <= fsync_d;
            frame_cnt_q <= frame_cnt_d;
            vid_de_q    <= vid_de_d;
            vid_pixel_q <= vid_pixel_d;
            vid_hsync_q <= vid_hsync_d;
            vid_vsync_q <= vid_vsync_d;
        end
    end

    assign hpos      = hcnt_q;
    assign vpos      = vcnt_q;
    assign fsync     = fsync_q;
    assign frame_cnt = frame_cnt_q;
    assign vid_de    = vid_de_q;
    assign vid_pixel = vid_pixel_q;
    assign vid_hsync = vid_hsync_q;
    assign vid_vsync = vid_vsync_q;

endmodule

// File: tb/tb_raster_timing_gen.sv
// Bench for raster_timing_gen on a shrunk 25x14 raster (16x8 active), plus an active-low sync instance.
module tb_raster_timing_gen;

    localparam int HRES = 16, H_FP = 2, H_SYNC = 3, H_BP = 4;
    localparam int VRES = 8,  V_FP = 1, V_SYNC = 2, V_BP = 3;
    localparam int H_TOTAL = 25, V_TOTAL = 14, FRAME = 350;
    localparam logic [23:0] BG = 24'h123456;

    logic        pixel_clk = 1'b0;
    logic        rst = 1'b1;
    logic        test_en = 1'b0;
    logic [23:0] a_pix = '0, b_pix = '0;
    logic        a_act = 1'b0, b_act = 1'b0;

    logic signed [11:0] hpos, vpos, n_hpos, n_vpos;
    logic        fsync, n_fsync;
    logic [15:0] frame_cnt, n_frame_cnt;
    logic        vid_hsync, vid_vsync, vid_de, n_vid_hsync, n_vid_vsync, n_vid_de;
    logic [23:0] vid_pixel, n_vid_pixel;

    int checks = 0;
    int failures = 0;

    always #5 pixel_clk = ~pixel_clk;

    raster_timing_gen #(
        .HRES(HRES), .VRES(VRES), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .SYNC_POL(1'b1), .BG_COLOR(BG)
    ) u_dut (
        .pixel_clk(pixel_clk), .rst(rst),
`ifdef RASTER_TEST_PATTERN_EN
        .test_en(test_en),
`endif
        .hpos(hpos), .vpos(vpos), .fsync(fsync),
        .obj_a_pixel(a_pix), .obj_a_active(a_act),
        .obj_b_pixel(b_pix), .obj_b_active(b_act),
        .frame_cnt(frame_cnt), .vid_hsync(vid_hsync), .vid_vsync(vid_vsync),
        .vid_de(vid_de), .vid_pixel(vid_pixel)
    );

    raster_timing_gen #(
        .HRES(HRES), .VRES(VRES), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .SYNC_POL(1'b0), .BG_COLOR(BG)
    ) u_neg (
        .pixel_clk(pixel_clk), .rst(rst),
`ifdef RASTER_TEST_PATTERN_EN
        .test_en(test_en),
`endif
        .hpos(n_hpos), .vpos(n_vpos), .fsync(n_fsync),
        .obj_a_pixel(a_pix), .obj_a_active(a_act),
        .obj_b_pixel(b_pix), .obj_b_active(b_act),
        .frame_cnt(n_frame_cnt), .vid_hsync(n_vid_hsync), .vid_vsync(n_vid_vsync),
        .vid_de(n_vid_de), .vid_pixel(n_vid_pixel)
    );

    typedef struct {
        int          hp;
        int          vp;
        logic        a_act;
        logic [23:0] a_pix;
        logic        b_act;
        logic [23:0] b_pix;
        logic [23:0] exp_pix;
        logic        exp_de;
    } vec_t;

    localparam int NV = 9;
    vec_t vec [NV];

    task automatic tick();
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] u12(input logic signed [11:0] v);
        return {20'd0, v};
    endfunction

    task automatic wait_pos(input int h, input int v, output logic ok);
        ok = 1'b0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            if (int'(hpos) == h && int'(vpos) == v) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          mh, mv, fcount, nfs, last_fs, spacing_bad, fs_early;
        logic        de_p, hs_p, vs_p, exp_fs, ok;
        logic [23:0] pix_p;

        vec[0] = '{3,  2,  1'b1, 24'h00FF90, 1'b1, 24'hFF0000, 24'h00FF90, 1'b1};
        vec[1] = '{3,  2,  1'b0, 24'h00FF90, 1'b1, 24'hFF0000, 24'hFF0000, 1'b1};
        vec[2] = '{3,  2,  1'b0, 24'h00FF90, 1'b0, 24'hFF0000, BG,         1'b1};
        vec[3] = '{17, 2,  1'b1, 24'h00FF90, 1'b0, 24'h000000, 24'h000000, 1'b0};
        vec[4] = '{15, 7,  1'b1, 24'hAABBCC, 1'b1, 24'h111111, 24'hAABBCC, 1'b1};
        vec[5] = '{0,  8,  1'b1, 24'hAABBCC, 1'b0, 24'h000000, 24'h000000, 1'b0};
        vec[6] = '{16, 0,  1'b0, 24'h000000, 1'b1, 24'h0000FF, 24'h000000, 1'b0};
        vec[7] = '{0,  0,  1'b0, 24'h000000, 1'b1, 24'h0000FF, 24'h0000FF, 1'b1};
        vec[8] = '{24, 13, 1'b1, 24'hFFFFFF, 1'b1, 24'hFFFFFF, 24'h000000, 1'b0};

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_hpos", u12(hpos), 0);
        chk("rst_vpos", u12(vpos), 0);
        chk("rst_fsync", {31'd0, fsync}, 0);
        chk("rst_frame_cnt", {16'd0, frame_cnt}, 0);
        chk("rst_de", {31'd0, vid_de}, 0);
        chk("rst_pixel", {8'd0, vid_pixel}, 0);
        chk("rst_hsync", {31'd0, vid_hsync}, 0);
        chk("rst_vsync", {31'd0, vid_vsync}, 0);
        chk("rst_hsync_neg", {31'd0, n_vid_hsync}, 1);
        chk("rst_vsync_neg", {31'd0, n_vid_vsync}, 1);

        // Three full frames against a cycle-level reference
        rst = 1'b0;
        mh = 0; mv = 0; fcount = 0; nfs = 0; last_fs = -1; spacing_bad = 0;
        de_p = 1'b0; hs_p = 1'b0; vs_p = 1'b0; pix_p = '0;
        for (int n = 0; n < 3 * FRAME; n++) begin
            exp_fs = (mh == 0 && mv == VRES);
            if (exp_fs) fcount++;
            chk("scan_hpos", u12(hpos), mh);
            chk("scan_vpos", u12(vpos), mv);
            chk("scan_fsync", {31'd0, fsync}, {31'd0, exp_fs});
            chk("scan_frame_cnt", {16'd0, frame_cnt}, fcount);
            chk("scan_de", {31'd0, vid_de}, {31'd0, de_p});
            chk("scan_hsync", {31'd0, vid_hsync}, {31'd0, hs_p});
            chk("scan_vsync", {31'd0, vid_vsync}, {31'd0, vs_p});
            chk("scan_pixel", {8'd0, vid_pixel}, {8'd0, pix_p});
            chk("scan_hsync_neg", {31'd0, n_vid_hsync}, {31'd0, ~hs_p});
            chk("scan_vsync_neg", {31'd0, n_vid_vsync}, {31'd0, ~vs_p});
            if (fsync) begin
                nfs++;
                if (last_fs >= 0 && n - last_fs != FRAME) spacing_bad++;
                last_fs = n;
            end
            de_p  = (mh < HRES) && (mv < VRES);
            hs_p  = (mh >= HRES + H_FP) && (mh <= HRES + H_FP + H_SYNC - 1);
            vs_p  = (mv >= VRES + V_FP) && (mv <= VRES + V_FP + V_SYNC - 1);
            pix_p = de_p ? BG : 24'd0;
            mh++;
            if (mh == H_TOTAL) begin
                mh = 0;
                mv = (mv == V_TOTAL - 1) ? 0 : mv + 1;
            end
            tick();
        end
        chk("fsync_count", nfs, 3);
        chk("fsync_spacing", spacing_bad, 0);
        chk("frames_done", {16'd0, frame_cnt}, 3);
        chk("wrap_hpos", u12(hpos), 0);
        chk("wrap_vpos", u12(vpos), 0);

        // Compositing priority and blanking vectors
        for (int i = 0; i < NV; i++) begin
            wait_pos(vec[i].hp, vec[i].vp, ok);
            chk($sformatf("vec%0d_reach", i), {31'd0, ok}, 1);
            a_act = vec[i].a_act; a_pix = vec[i].a_pix;
            b_act = vec[i].b_act; b_pix = vec[i].b_pix;
            tick();
            chk($sformatf("vec%0d_pixel", i), {8'd0, vid_pixel}, {8'd0, vec[i].exp_pix});
            chk($sformatf("vec%0d_de", i), {31'd0, vid_de}, {31'd0, vec[i].exp_de});
            a_act = 1'b0; b_act = 1'b0; a_pix = '0; b_pix = '0;
        end

        // Mid-frame reset aborts the frame and delays the next fsync
        wait_pos(5, 4, ok);
        chk("midrst_reach", {31'd0, ok}, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_hpos", u12(hpos), 0);
        chk("midrst_vpos", u12(vpos), 0);
        chk("midrst_de", {31'd0, vid_de}, 0);
        chk("midrst_frame_cnt", {16'd0, frame_cnt}, 0);
        chk("midrst_fsync", {31'd0, fsync}, 0);
        fs_early = 0;
        for (int k = 0; k < VRES * H_TOTAL; k++) begin
            if (fsync) fs_early++;
            tick();
        end
        chk("midrst_no_early_fsync", fs_early, 0);
        chk("midrst_fsync_due", {31'd0, fsync}, 1);
        chk("midrst_fsync_hpos", u12(hpos), 0);
        chk("midrst_fsync_vpos", u12(vpos), VRES);
        chk("midrst_frame_cnt_1", {16'd0, frame_cnt}, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
